// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the two-requester SPI arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    localparam int TMO_W_DEF = 12;

endpackage

// File: rtl/spi_req_slot.sv
// One requester slot: a pending flag plus the command captured with it.
module spi_req_slot
    import spi_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_snd,
    input  logic [15:0] i_cmd,
    input  logic        i_in_flight,
    input  logic        i_grant,
    output logic        o_pend,
    output logic [15:0] o_cmd
);

    logic        r_pend;
    logic [15:0] r_cmd;

    // Grant only happens while pending and capture only while not pending,
    // so the two branches are never wanted in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_cmd  <= 16'h0000;
        end else if (i_grant) begin
            r_pend <= 1'b0;
        end else if (i_snd && !r_pend && !i_in_flight) begin
            r_pend <= 1'b1;
            r_cmd  <= i_cmd;
        end
    end

    assign o_pend = r_pend;
    assign o_cmd  = r_cmd;

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI monarch between two requesters.
// Optional WAIT timeout is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd0,
    input  logic [15:0] cmd0,
    output logic        done0,
    input  logic        snd1,
    input  logic [15:0] cmd1,
    output logic        done1,
    output logic [15:0] resp,
    output logic        busy,
    output logic        tmo,
    output logic        spi_snd,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_resp
);

    arb_state_t  r_state, w_state_next;
    logic        r_gnt;
    logic        r_rr;
    logic [15:0] r_spi_cmd;
    logic [15:0] r_resp;
    logic [1:0]  r_done;

    logic [1:0]  w_snd, w_pend, w_grant, w_in_flight;
    logic [15:0] w_cmd_in [2];
    logic [15:0] w_slot_cmd [2];
    logic        w_launch, w_sel, w_fin, w_tmo_hit;

    assign w_snd       = {snd1, snd0};
    assign w_cmd_in[0] = cmd0;
    assign w_cmd_in[1] = cmd1;

    assign w_launch = (r_state == IDLE) && (|w_pend);
    assign w_sel    = (&w_pend) ? r_rr : w_pend[1];
    assign w_fin    = (r_state == WAIT) && (spi_done || w_tmo_hit);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign w_grant[gi]     = w_launch && (w_sel == 1'(gi));
            assign w_in_flight[gi] = (r_state != IDLE) && (r_gnt == 1'(gi));

            spi_req_slot u_slot (
                .clk         (clk),
                .rst         (rst),
                .i_snd       (w_snd[gi]),
                .i_cmd       (w_cmd_in[gi]),
                .i_in_flight (w_in_flight[gi]),
                .i_grant     (w_grant[gi]),
                .o_pend      (w_pend[gi]),
                .o_cmd       (w_slot_cmd[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|w_pend) w_state_next = LAUNCH;
            LAUNCH:  w_state_next = WAIT;
            WAIT:    if (w_fin) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt     <= 1'b0;
            r_rr      <= 1'b0;
            r_spi_cmd <= 16'h0000;
            r_resp    <= 16'h0000;
            r_done    <= 2'b00;
        end else begin
            r_done <= 2'b00;
            if (w_launch) begin
                r_gnt     <= w_sel;
                r_spi_cmd <= w_slot_cmd[w_sel];
            end
            // A real completion wins over a timeout landing in the same cycle.
            if (w_fin) begin
                r_resp        <= spi_done ? spi_resp : 16'h0000;
                r_done[r_gnt] <= 1'b1;
                r_rr          <= ~r_gnt;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo;

    // Counter is zero in the first WAIT cycle, so the hit at TMO_LAST ends
    // WAIT after exactly 2^TMO_W-1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else begin
            r_tmo <= w_fin && !spi_done;
            if (r_state == LAUNCH) begin
                r_tmo_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    assign tmo       = r_tmo;
`else
    assign w_tmo_hit = 1'b0;
    assign tmo       = 1'b0;
`endif

    assign done0   = r_done[0];
    assign done1   = r_done[1];
    assign resp    = r_resp;
    assign busy    = (r_state != IDLE);
    assign spi_snd = (r_state == LAUNCH);
    assign spi_cmd = r_spi_cmd;

endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 Parameter TMO_W, default 12: timeout counter width; a transaction times out after 2^TMO_W-1 WAIT cycles.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 snd0  input  1  requester 0 transaction request, one-cycle pulse.
REQ-005 cmd0  input  16  requester 0 SPI command, sampled when snd0=1.
REQ-006 done0  output  1  requester 0 completion, one-cycle pulse.
REQ-007 snd1  input  1  requester 1 transaction request, one-cycle pulse.
REQ-008 cmd1  input  16  requester 1 SPI command, sampled when snd1=1.
REQ-009 done1  output  1  requester 1 completion, one-cycle pulse.
REQ-010 resp  output  16  response of the completed transaction; valid in the done0/done1 cycle and held until the next completion.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 tmo  output  1  timeout pulse, coincident with the aborted requester's done pulse.
REQ-013 spi_snd  output  1  start pulse to the SPI monarch.
REQ-014 spi_cmd  output  16  command to the SPI monarch; stable from LAUNCH through the end of WAIT.
REQ-015 spi_done  input  1  SPI monarch completion pulse.
REQ-016 spi_resp  input  16  SPI monarch response word.

Function
REQ-017 Each requester has a pending flag and a command register; snd_k=1 while pend_k=0 and requester k is not in flight sets pend_k and captures cmd_k at that edge.
REQ-018 snd_k while pend_k=1 or while requester k is in flight shall be ignored: no capture, no error.
REQ-019 FSM states shall be IDLE, LAUNCH and WAIT; reset state is IDLE.
REQ-020 IDLE with any pend set -> LAUNCH next edge: grant the pending requester (both pending: the one selected by rr_ptr), clear its pend, load spi_cmd from its command register.
REQ-021 LAUNCH: spi_snd=1 for exactly one cycle, then unconditionally go to WAIT.
REQ-022 WAIT: on spi_done=1, register resp<=spi_resp, pulse done_g one cycle later, go to IDLE, and set rr_ptr to the non-granted requester.
REQ-023 Minimum latency: snd_k at cycle n -> spi_snd at cycle n+2 (pend capture, then grant); done_k pulses 1 cycle after spi_done.
REQ-024 Back-to-back: a request pending on return to IDLE shall be granted the next cycle; IDLE therefore lasts 1 cycle between transactions.
REQ-025 A request arriving during LAUNCH/WAIT from the non-granted requester shall be captured and served next, with no loss.
REQ-026 spi_done outside WAIT shall be ignored.
REQ-027 done0 and done1 shall never be asserted in the same cycle.

Reset
REQ-028 rst=1 forces state=IDLE, pend0=pend1=0, both command regs=0, spi_cmd=0, resp=0, rr_ptr=0, timeout counter=0.
REQ-029 rst=1 forces spi_snd=0, done0=0, done1=0, tmo=0, busy=0.
REQ-030 rst asserted mid-transaction abandons it with no done pulse; a late spi_done after reset shall be ignored (state is IDLE).

Configuration
REQ-031 Macro SPI_ARB_TIMEOUT_EN: when defined, a TMO_W-bit counter clears on entering WAIT and increments each WAIT cycle.
REQ-032 With SPI_ARB_TIMEOUT_EN, reaching all-ones without spi_done -> IDLE, resp<=16'h0000, and done_g plus tmo pulse together; rr_ptr advances as in REQ-022.
REQ-033 Without SPI_ARB_TIMEOUT_EN, no counter is built, tmo is tied to 0, and WAIT holds indefinitely until spi_done.

Structure
REQ-034 Package spi_arb_pkg shall hold typedef arb_state_t {IDLE, LAUNCH, WAIT} and localparam TMO_W_DEF=12.
REQ-035 Sub-module spi_req_slot (pend flag + 16-bit command capture, per REQ-017/018) shall be instantiated twice.

Verification
REQ-036 snd0 with cmd0=16'h0D02 in idle -> spi_snd 2 cycles later with spi_cmd=16'h0D02; spi_done with spi_resp=16'h00A5 -> done0 next cycle, resp=16'h00A5, done1 stays 0.
REQ-037 snd0 and snd1 in the same cycle after reset (cmd0=16'hA600, cmd1=16'hA700) -> 16'hA600 issued first, then 16'hA700 one IDLE cycle after done0.
REQ-038 snd1 during requester 0's WAIT, then snd0 again -> requester 1 served before requester 0's second request (round-robin).
REQ-039 Repeated snd0 while requester 0 is pending -> exactly one spi_snd and one done0 for requester 0.
REQ-040 SPI_ARB_TIMEOUT_EN with TMO_W=4 and spi_done withheld -> 15 WAIT cycles, then done0 and tmo pulse together with resp=16'h0000, then return to IDLE.
REQ-041 rst asserted in WAIT, then spi_done -> no done pulse, busy=0, next snd1 serviced normally.
